// File: rtl/tl_rx_vc_pkg.sv
// Shared widths, ctrl-bus field layout and FSM encoding for the RX VC buffer read side.
package tl_rx_vc_pkg;

    localparam int DW               = 32;
    localparam int HDR_BUFFER_WIDTH = 4 * DW;
    localparam int BEAT_SIZE        = 32 * DW;
    localparam int R_CTRL_BUS_WIDTH = 6;
    localparam int LEN_WIDTH        = 10;
    localparam int DW_CNT_WIDTH     = 6;

    localparam int DWS_PER_ENTRY = 8;
    localparam int DWS_PER_BEAT  = 32;

    // Read control bus: {hdr_inc_en, data_inc_en, data_inc_value[2:0], data_allignment}
    localparam int CTRL_HDR_INC     = 5;
    localparam int CTRL_DATA_INC    = 4;
    localparam int CTRL_INC_VAL_LSB = 1;
    localparam int CTRL_INC_VAL_W   = 3;
    localparam int CTRL_ALIGN       = 0;

    // Bit positions inside the 3-bit Fmt field
    localparam int FMT_HAS_DATA = 1;
    localparam int FMT_4DW      = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOP  = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/tl_rx_hdr_len_decode.sv
// Combinational decode of header DW0: payload presence, beat count and DWs in the last beat.
module tl_rx_hdr_len_decode
    import tl_rx_vc_pkg::*;
(
    input  logic [DW-1:0]           i_dw0,
    output logic                    o_has_data,
    output logic [DW_CNT_WIDTH-1:0] o_beats,
    output logic [DW_CNT_WIDTH-1:0] o_last_dw
);

    logic [2:0]           fmt;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] len_m1;
    logic                 unused_dw0_fields;

    always_comb begin
        fmt        = i_dw0[DW-1 -: 3];
        len        = i_dw0[LEN_WIDTH-1:0];
        o_has_data = fmt[FMT_HAS_DATA];
        // Length 0 encodes 1024 DW; len-1 wraps to 1023, which keeps both formulas uniform.
        len_m1     = len - LEN_WIDTH'(1);
        o_beats    = {1'b0, len_m1[LEN_WIDTH-1:5]} + DW_CNT_WIDTH'(1);
        o_last_dw  = {1'b0, len_m1[4:0]} + DW_CNT_WIDTH'(1);
    end

    assign unused_dw0_fields = ^{i_dw0[DW-4:LEN_WIDTH], fmt[2], fmt[FMT_4DW]};

endmodule

// File: rtl/tl_rx_vc_read_ctrl.sv
// Read-side sequencer for one RX VC buffer: frames each TLP as SOP/EOP beats and drives the read pointers.
module tl_rx_vc_read_ctrl
    import tl_rx_vc_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_hdr_empty_flag,
    input  logic                        i_data_empty_flag,
    input  logic [HDR_BUFFER_WIDTH-1:0] i_r_tlp_hdr,
    input  logic [BEAT_SIZE-1:0]        i_r_tlp_data,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_ctrl_bus,
    output logic                        o_tlp_valid,
    input  logic                        i_tlp_ready,
    output logic                        o_tlp_sop,
    output logic                        o_tlp_eop,
    output logic [HDR_BUFFER_WIDTH-1:0] o_tlp_hdr,
    output logic [BEAT_SIZE-1:0]        o_tlp_data,
    output logic [DW_CNT_WIDTH-1:0]     o_tlp_dw_cnt
);

    rd_state_e                 state;
    rd_state_e                 state_nxt;
    logic                      has_data_q;
    logic [DW_CNT_WIDTH-1:0]   beats_left_q;
    logic [DW_CNT_WIDTH-1:0]   last_dw_q;

    logic                      dec_has_data;
    logic [DW_CNT_WIDTH-1:0]   dec_beats;
    logic [DW_CNT_WIDTH-1:0]   dec_last_dw;

    logic                      start;
    logic                      last_beat;
    logic [DW_CNT_WIDTH-1:0]   beat_dw_cnt;
    logic                      accept;

    function automatic logic [CTRL_INC_VAL_W-1:0] dws_to_entries(input logic [DW_CNT_WIDTH-1:0] dws);
        logic [DW_CNT_WIDTH:0] rounded;
        rounded = {1'b0, dws} + (DW_CNT_WIDTH+1)'(DWS_PER_ENTRY - 1);
        return CTRL_INC_VAL_W'(rounded / (DW_CNT_WIDTH+1)'(DWS_PER_ENTRY));
    endfunction

    tl_rx_hdr_len_decode u_hdr_len_decode (
        .i_dw0      (i_r_tlp_hdr[HDR_BUFFER_WIDTH-1 -: DW]),
        .o_has_data (dec_has_data),
        .o_beats    (dec_beats),
        .o_last_dw  (dec_last_dw)
    );

    // A data TLP is only started once its first beat is already in the data FIFO,
    // so SOP can hold valid high without ever presenting an empty FIFO.
    assign start = (state == ST_IDLE) && !i_hdr_empty_flag &&
                   (!dec_has_data || !i_data_empty_flag);

    assign last_beat   = !has_data_q || (beats_left_q == DW_CNT_WIDTH'(1));
    assign beat_dw_cnt = !has_data_q ? '0 :
                         last_beat   ? last_dw_q : DW_CNT_WIDTH'(DWS_PER_BEAT);

    always_comb begin
        o_tlp_valid  = 1'b0;
        o_tlp_sop    = 1'b0;
        o_tlp_eop    = 1'b0;
        o_tlp_hdr    = '0;
        o_tlp_data   = '0;
        o_tlp_dw_cnt = '0;
        // Outputs are forced quiet during reset so an abandoned TLP cannot move the pointers.
        if (!i_rst && (state != ST_IDLE)) begin
            o_tlp_eop    = last_beat;
            o_tlp_dw_cnt = beat_dw_cnt;
            if (state == ST_SOP) begin
                o_tlp_valid = 1'b1;
                o_tlp_sop   = 1'b1;
                o_tlp_hdr   = i_r_tlp_hdr;
                if (has_data_q) begin
                    o_tlp_data = i_r_tlp_data;
                end
            end else begin
                o_tlp_valid = !i_data_empty_flag;
                if (!i_data_empty_flag) begin
                    o_tlp_data = i_r_tlp_data;
                end
            end
        end
    end

    assign accept = o_tlp_valid && i_tlp_ready;

    always_comb begin
        o_r_ctrl_bus = '0;
        if (accept) begin
            o_r_ctrl_bus[CTRL_HDR_INC] = (state == ST_SOP);
            if (has_data_q) begin
                o_r_ctrl_bus[CTRL_DATA_INC] = 1'b1;
                o_r_ctrl_bus[CTRL_INC_VAL_LSB +: CTRL_INC_VAL_W] = dws_to_entries(beat_dw_cnt);
                o_r_ctrl_bus[CTRL_ALIGN] = last_beat;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SOP;
                end
            end
            ST_SOP, ST_DATA: begin
                if (accept) begin
                    state_nxt = last_beat ? ST_IDLE : ST_DATA;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            has_data_q   <= 1'b0;
            beats_left_q <= '0;
            last_dw_q    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                has_data_q   <= dec_has_data;
                beats_left_q <= dec_beats;
                last_dw_q    <= dec_last_dw;
            end else if (accept) begin
                beats_left_q <= beats_left_q - DW_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tl_rx_vc_read_ctrl.sv
// Bench for tl_rx_vc_read_ctrl: buffer model plus a per-TLP beat reference, directed and random traffic.
module tb_tl_rx_vc_read_ctrl;

    logic          clk = 1'b0;
    logic          rst;
    logic          hdr_empty;
    logic          data_empty;
    logic [127:0]  r_hdr;
    logic [1023:0] r_data;
    logic [5:0]    ctrl;
    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic [127:0]  hdr;
    logic [1023:0] data;
    logic [5:0]    dw_cnt;

    always #5 clk = ~clk;

    tl_rx_vc_read_ctrl dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_hdr_empty_flag  (hdr_empty),
        .i_data_empty_flag (data_empty),
        .i_r_tlp_hdr       (r_hdr),
        .i_r_tlp_data      (r_data),
        .o_r_ctrl_bus      (ctrl),
        .o_tlp_valid       (valid),
        .i_tlp_ready       (ready),
        .o_tlp_sop         (sop),
        .o_tlp_eop         (eop),
        .o_tlp_hdr         (hdr),
        .o_tlp_data        (data),
        .o_tlp_dw_cnt      (dw_cnt)
    );

    typedef struct {
        logic [127:0] hdr;
        bit           hd;
        int           len;
        int           base;
    } tlp_t;

    tlp_t          hq[$];
    logic [31:0]   dmem [0:16383];
    int            wptr;
    int            rptr;
    int            n_cmp;
    int            n_fail;
    bit            rst_req;
    bit            force_empty;
    bit            ready_lo;
    bit            rand_empty;
    int            rdy_pct;
    bit            pend_pop;
    bit            pend_rst;
    int            pend_inc;
    bit            busy;
    int            idx;
    tlp_t          cur;
    logic [1023:0] held_data;
    logic [5:0]    held_dw_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_sop"}, sop, 0);
        chk({tag, "_eop"}, eop, 0);
        chk({tag, "_hdr"}, hdr, 0);
        chk({tag, "_dw_cnt"}, dw_cnt, 0);
        chk({tag, "_ctrl"}, ctrl, 0);
        chk({tag, "_data_zero"}, data == '0, 1);
    endtask

    task automatic push_tlp(input logic [2:0] fmt, input int len);
        tlp_t t;
        int   l;
        int   ne;
        t.hdr  = {fmt, 19'($urandom), 10'(len), $urandom, $urandom, $urandom};
        t.hd   = fmt[1];
        t.len  = len;
        t.base = wptr * 8;
        if (t.hd) begin
            l  = (len == 0) ? 1024 : len;
            ne = (l + 7) / 8;
            for (int j = 0; j < ne * 8; j++) dmem[(t.base + j) % 16384] = $urandom;
            wptr += ne;
        end
        hq.push_back(t);
    endtask

    // Buffer model: applies the pointer moves requested in the previous cycle, then presents its head.
    task automatic drive();
        if (pend_rst) begin
            hq.delete();
            rptr = 0;
            wptr = 0;
            busy = 0;
        end else begin
            if (pend_pop && hq.size() > 0) void'(hq.pop_front());
            rptr += pend_inc;
        end
        pend_rst = 0;
        pend_pop = 0;
        pend_inc = 0;
        rst = rst_req;
        if (rand_empty) force_empty = ($urandom_range(99) < 15);
        hdr_empty  = (hq.size() == 0);
        r_hdr      = hdr_empty ? '0 : hq[0].hdr;
        data_empty = (rptr == wptr) || force_empty;
        for (int i = 0; i < 32; i++) r_data[1023 - 32*i -: 32] = dmem[(rptr * 8 + i) % 16384];
        ready = !ready_lo && ($urandom_range(99) < rdy_pct);
    endtask

    task automatic check_cycle();
        int         l;
        int         nb;
        int         dwc;
        bit         e_eop;
        bit         acc;
        bit         ok;
        logic [2:0] e_val;
        logic [5:0] e_ctrl;
        if (rst) begin
            chk("rst_valid", valid, 0);
            chk("rst_ctrl", ctrl, 0);
            chk("rst_sop", sop, 0);
            chk("rst_hdr", hdr, 0);
            pend_rst = 1;
            return;
        end
        if (!busy) begin
            chk("idle_valid", valid, 0);
            chk("idle_ctrl", ctrl, 0);
            if (!hdr_empty && (!hq[0].hd || !data_empty)) begin
                busy = 1;
                idx  = 0;
                cur  = hq[0];
            end
        end else begin
            l     = (cur.len == 0) ? 1024 : cur.len;
            nb    = cur.hd ? (l + 31) / 32 : 1;
            e_eop = (idx == nb - 1);
            dwc   = !cur.hd ? 0 : (e_eop ? l - 32 * (nb - 1) : 32);
            chk("valid", valid, (idx == 0) ? 1'b1 : !data_empty);
            if (valid) begin
                chk("sop", sop, idx == 0);
                chk("eop", eop, e_eop);
                chk("dw_cnt", dw_cnt, dwc);
                if (idx == 0) chk("hdr", hdr, cur.hdr);
                ok = 1;
                if (cur.hd) begin
                    for (int i = 0; i < dwc; i++)
                        if (data[1023 - 32*i -: 32] !== dmem[(cur.base + 32 * idx + i) % 16384]) ok = 0;
                end else begin
                    ok = (data == '0);
                end
                chk("data", ok, 1);
            end
            acc    = valid && ready;
            e_val  = cur.hd ? 3'((dwc + 7) / 8) : 3'd0;
            e_ctrl = acc ? {(idx == 0), cur.hd, e_val, (cur.hd && e_eop)} : 6'd0;
            chk("ctrl", ctrl, e_ctrl);
            if (acc) begin
                idx++;
                if (idx == nb) busy = 0;
            end
        end
        pend_pop = ctrl[5];
        pend_inc = ctrl[4] ? int'(ctrl[3:1]) : 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((hq.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic reach_beat2(input string tag);
        int n;
        n = 0;
        while (!(busy && idx == 1) && n < 30) begin
            step();
            n++;
        end
        chk(tag, n < 30, 1);
    endtask

    initial begin
        int f;
        int len;
        n_cmp = 0;        n_fail = 0;
        rst_req = 1;      rdy_pct = 100;
        ready_lo = 0;     force_empty = 0;  rand_empty = 0;
        busy = 0;         idx = 0;
        wptr = 0;         rptr = 0;
        pend_pop = 0;     pend_rst = 0;     pend_inc = 0;
        rst = 1;          ready = 0;
        hdr_empty = 1;    data_empty = 1;
        r_hdr = '0;       r_data = '0;

        repeat (3) step();
        rst_req = 0;
        step();
        chk_idle_zero("post_reset");

        push_tlp(3'b000, 1);
        drain(20);
        push_tlp(3'b010, 1);
        drain(20);
        push_tlp(3'b010, 40);
        drain(20);
        push_tlp(3'b010, 0);
        drain(100);
        step();
        chk("ptr_directed", rptr, wptr);

        // Backpressure on beat 2, then data FIFO bubbles
        push_tlp(3'b011, 96);
        reach_beat2("bp_reach_beat2");
        ready_lo = 1;
        step();
        chk("bp_valid", valid, 1);
        held_data   = data;
        held_dw_cnt = dw_cnt;
        repeat (4) begin
            step();
            chk("bp_hold_valid", valid, 1);
            chk("bp_hold_data", data === held_data, 1);
            chk("bp_hold_dw_cnt", dw_cnt, held_dw_cnt);
        end
        ready_lo    = 0;
        force_empty = 1;
        repeat (3) begin
            step();
            chk("empty_valid", valid, 0);
        end
        force_empty = 0;
        drain(20);
        step();
        chk("ptr_bp", rptr, wptr);

        // Reset in the middle of a two-beat TLP
        push_tlp(3'b010, 64);
        reach_beat2("rst_reach_data");
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        chk_idle_zero("after_mid_rst");
        push_tlp(3'b010, 5);
        drain(20);
        step();
        chk("ptr_after_rst", rptr, wptr);

        rdy_pct    = 70;
        rand_empty = 1;
        for (int k = 0; k < 30; k++) begin
            f   = $urandom_range(3);
            len = ($urandom_range(9) == 0) ? 0 : $urandom_range(96, 1);
            push_tlp(3'(f), len);
            if ($urandom_range(2) == 0) drain(3000);
        end
        rand_empty  = 0;
        force_empty = 0;
        rdy_pct     = 100;
        drain(3000);
        step();
        chk("ptr_random", rptr, wptr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
